eq_spi_frame_slave: RTL and testbench

Parametrised successor to the single-band EQ SPI slave. It receives a multi-band EQ gain frame from the MCU over SPI and commits it atomically to the EQ core. It returns the most recent core result, or reads back the committed gains when no result is pending. It runs entirely in the 24 MHz system clock domain: SPI pins are synchronised and edge-detected, with no logic clocked by sck.

---
 rtl/eq_spi_frame_slave_if.sv | 11 +
 rtl/eq_spi_frame_slave.sv | 136 +++++++++++++
 tb/tb_eq_spi_frame_slave.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/eq_spi_frame_slave_if.sv
// SPI pin bundle between the MCU (master) and the EQ frame slave.
// Mode 0 SPI plus a frame strobe held high for the whole transfer.
interface eq_spi_frame_slave_if;
  logic sck;
  logic sdi;
  logic load;
  logic sdo;

  modport master (output sck, output sdi, output load, input sdo);
  modport slave  (input sck, input sdi, input load, output sdo);
endinterface

// File: rtl/eq_spi_frame_slave.sv
// Multi-band EQ gain frame receiver: SPI pins are oversampled in the clk domain,
// frames commit atomically, and the MISO path returns the latest core result or gain readback.
module eq_spi_frame_slave #(
  parameter int                NUM_BANDS  = 4,
  parameter int                GAIN_W     = 8,
  parameter int                RESULT_W   = 8,
  parameter logic [GAIN_W-1:0] GAIN_RESET = 8'h80
) (
  input  logic                          clk,
  input  logic                          nreset,
  eq_spi_frame_slave_if.slave           spi,
  input  logic                          core_done,
  input  logic [RESULT_W-1:0]           result,
  output logic [NUM_BANDS*GAIN_W-1:0]   gains,
  output logic                          gains_valid,
  output logic                          frame_err,
  output logic                          result_pending
);
  localparam int FRAME_BITS = NUM_BANDS * GAIN_W;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  // Load synchroniser resets high so a strobe already active at reset release is never seen as a rise.
  localparam logic [2:0] SYNC_RST = 3'b001;

  typedef enum logic [1:0] {IDLE, RECV, COMMIT} state_t;

  logic [2:0] pin_vec;
  logic [2:0] s2_vec;
  logic [2:0] s3_vec;

  assign pin_vec = {spi.sck, spi.sdi, spi.load};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      logic [2:0] pipe_reg;
      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          pipe_reg <= {3{SYNC_RST[gi]}};
        end else begin
          pipe_reg <= {pipe_reg[1:0], pin_vec[gi]};
        end
      end
      assign s2_vec[gi] = pipe_reg[1];
      assign s3_vec[gi] = pipe_reg[2];
    end
  endgenerate

  logic sck_rise, sck_fall, load_rise, load_fall, sdi_s;
  assign sck_rise  = s2_vec[2] & ~s3_vec[2];
  assign sck_fall  = ~s2_vec[2] & s3_vec[2];
  assign sdi_s     = s2_vec[1];
  assign load_rise = s2_vec[0] & ~s3_vec[0];
  assign load_fall = ~s2_vec[0] & s3_vec[0];

  state_t                state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [FRAME_BITS-1:0] rx_reg;
  logic [FRAME_BITS-1:0] tx_reg;
  logic [FRAME_BITS-1:0] gains_reg;
  logic                  gains_valid_reg;
  logic                  frame_err_reg;
  logic [RESULT_W-1:0]   hold_reg;
  logic                  pending_reg;
  logic                  done_d_reg;
  logic                  done_rise;

  assign done_rise = core_done & ~done_d_reg;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      rx_reg          <= '0;
      tx_reg          <= '0;
      gains_reg       <= {NUM_BANDS{GAIN_RESET}};
      gains_valid_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
      hold_reg        <= '0;
      pending_reg     <= 1'b0;
      done_d_reg      <= 1'b0;
    end else begin
      gains_valid_reg <= 1'b0;
      done_d_reg      <= core_done;
      case (state_reg)
        IDLE: begin
          if (load_rise) begin
            state_reg <= RECV;
            cnt_reg   <= '0;
            rx_reg    <= '0;
            if (pending_reg) begin
              tx_reg      <= FRAME_BITS'(hold_reg) << (FRAME_BITS - RESULT_W);
              pending_reg <= 1'b0;
            end else begin
              tx_reg <= gains_reg;
            end
          end
        end
        RECV: begin
          // One slot past a full frame is still counted so overruns are distinguishable.
          if (sck_rise && cnt_reg <= CNT_FULL) begin
            rx_reg  <= {rx_reg[FRAME_BITS-2:0], sdi_s};
            cnt_reg <= cnt_reg + 1'b1;
          end
          if (sck_fall) begin
            tx_reg <= {tx_reg[FRAME_BITS-2:0], 1'b0};
          end
          if (load_fall) begin
            state_reg <= COMMIT;
          end
        end
        COMMIT: begin
          state_reg <= IDLE;
          if (cnt_reg == CNT_FULL) begin
            gains_reg       <= rx_reg;
            gains_valid_reg <= 1'b1;
            frame_err_reg   <= 1'b0;
          end else begin
            frame_err_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
      // Placed last so a capture coinciding with a frame start leaves the result pending.
      if (done_rise) begin
        hold_reg    <= result;
        pending_reg <= 1'b1;
      end
    end
  end

  assign spi.sdo        = tx_reg[FRAME_BITS-1];
  assign gains          = gains_reg;
  assign gains_valid    = gains_valid_reg;
  assign frame_err      = frame_err_reg;
  assign result_pending = pending_reg;
endmodule

// File: tb/tb_eq_spi_frame_slave.sv
// Directed and randomized frames against a transaction-level model of the EQ frame slave.
module tb_eq_spi_frame_slave;
  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        core_done = 1'b0;
  logic [7:0]  result = 8'h00;
  logic [31:0] gains;
  logic        gains_valid;
  logic        frame_err;
  logic        result_pending;

  eq_spi_frame_slave_if spi_bus();

  eq_spi_frame_slave dut (
    .clk            (clk),
    .nreset         (nreset),
    .spi            (spi_bus),
    .core_done      (core_done),
    .result         (result),
    .gains          (gains),
    .gains_valid    (gains_valid),
    .frame_err      (frame_err),
    .result_pending (result_pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int gv_count = 0;

  // Reference model state
  logic [31:0] m_gains;
  logic        m_err;
  logic        m_pend;
  logic [7:0]  m_hold;

  always @(negedge clk) if (gains_valid) gv_count++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic smp);
    spi_bus.sdi = b;
    clks(4);
    smp = spi_bus.sdo;
    spi_bus.sck = 1'b1;
    clks(8);
    spi_bus.sck = 1'b0;
    clks(4);
  endtask

  task automatic capture(input logic [7:0] v);
    result = v;
    core_done = 1'b1;
    clks(3);
    core_done = 1'b0;
    clks(2);
    m_hold = v;
    m_pend = 1'b1;
    check("pending_after_capture", {63'd0, result_pending}, 64'd1);
    $display("capture result=%h", v);
  endtask

  // Bit i of the frame is data[63-i]; a frame is good only with exactly 32 bits.
  task automatic frame(input string tag, input logic [63:0] data, input int nbits,
                       input logic race, input logic [7:0] race_val);
    logic [63:0] got;
    logic [63:0] exp;
    logic [31:0] tx;
    logic [31:0] g_before;
    int          gv0;
    logic        smp;
    logic        good;
    got = '0;
    exp = '0;
    tx = m_pend ? {m_hold, 24'h0} : m_gains;
    m_pend = 1'b0;
    spi_bus.load = 1'b1;
    if (race) begin
      clks(2);
      result = race_val;
      core_done = 1'b1;
      m_hold = race_val;
      m_pend = 1'b1;
      clks(2);
      core_done = 1'b0;
      clks(1);
    end else begin
      clks(5);
    end
    check($sformatf("%s_pending_start", tag), {63'd0, result_pending}, {63'd0, m_pend});
    for (int i = 0; i < nbits; i++) begin
      spi_bit(data[63-i], smp);
      got[63-i] = smp;
      exp[63-i] = (i < 32) ? tx[31-i] : 1'b0;
    end
    check($sformatf("%s_sdo", tag), got, exp);
    g_before = gains;
    gv0 = gv_count;
    spi_bus.load = 1'b0;
    good = (nbits == 32);
    if (good) m_gains = data[63:32];
    m_err = !good;
    clks(3);
    check($sformatf("%s_gains_pre", tag), {32'd0, gains}, {32'd0, g_before});
    clks(1);
    check($sformatf("%s_gains", tag), {32'd0, gains}, {32'd0, m_gains});
    check($sformatf("%s_gv_at4", tag), {63'd0, gains_valid}, {63'd0, good});
    clks(3);
    check($sformatf("%s_gv_count", tag), 64'(gv_count - gv0), {63'd0, good});
    check($sformatf("%s_frame_err", tag), {63'd0, frame_err}, {63'd0, m_err});
    check($sformatf("%s_pending_end", tag), {63'd0, result_pending}, {63'd0, m_pend});
    $display("frame %s bits=%0d data=%h sdo=%h gains=%h err=%b", tag, nbits, data, got, gains, frame_err);
  endtask

  initial begin
    logic        smp;
    logic [63:0] d;
    int          nb;
    int          gv0;
    spi_bus.sck = 1'b0;
    spi_bus.sdi = 1'b0;
    spi_bus.load = 1'b0;
    m_gains = 32'h80808080;
    m_err = 1'b0;
    m_pend = 1'b0;
    m_hold = 8'h00;

    clks(3);
    check("rst_gains", {32'd0, gains}, 64'h80808080);
    check("rst_gv", {63'd0, gains_valid}, 64'd0);
    check("rst_err", {63'd0, frame_err}, 64'd0);
    check("rst_pend", {63'd0, result_pending}, 64'd0);
    check("rst_sdo", {63'd0, spi_bus.sdo}, 64'd0);
    nreset = 1'b1;
    clks(2);

    frame("good", {32'h11223344, 32'h0}, 32, 1'b0, 8'h00);
    frame("short", {32'hDEADBEEF, 32'h0}, 31, 1'b0, 8'h00);

    // Reset in the middle of a frame, with load still high afterwards.
    spi_bus.load = 1'b1;
    clks(5);
    for (int i = 0; i < 10; i++) spi_bit(1'($urandom_range(0, 1)), smp);
    gv0 = gv_count;
    nreset = 1'b0;
    m_gains = 32'h80808080;
    m_err = 1'b0;
    m_pend = 1'b0;
    m_hold = 8'h00;
    clks(5);
    check("midrst_gains", {32'd0, gains}, 64'h80808080);
    check("midrst_gv", {63'd0, gains_valid}, 64'd0);
    check("midrst_err", {63'd0, frame_err}, 64'd0);
    check("midrst_sdo", {63'd0, spi_bus.sdo}, 64'd0);
    nreset = 1'b1;
    clks(4);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, smp);
    spi_bus.load = 1'b0;
    clks(8);
    check("midrst_no_commit", 64'(gv_count - gv0), 64'd0);
    check("midrst_gains_after", {32'd0, gains}, 64'h80808080);
    $display("midframe reset done gains=%h", gains);

    frame("after_rst", {32'hCAFE0123, 32'h0}, 32, 1'b0, 8'h00);
    capture(8'hA5);
    frame("result", {32'h55AA55AA, 32'h0}, 32, 1'b0, 8'h00);
    frame("overrun", {$urandom, $urandom}, 35, 1'b0, 8'h00);
    capture(8'hA5);
    frame("race", {32'h01020304, 32'h0}, 32, 1'b1, 8'h3C);
    frame("race_next", {32'h0A0B0C0D, 32'h0}, 32, 1'b0, 8'h00);

    for (int it = 0; it < 10; it++) begin
      d = {$urandom, $urandom};
      nb = ($urandom_range(0, 2) != 0) ? 32 : int'($urandom_range(1, 35));
      if ($urandom_range(0, 1) == 1) capture(8'($urandom_range(0, 255)));
      frame("rand", d, nb, $urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
